// File: rtl/emission_scan_scheduler_pkg.sv
// Shared definitions for the emission scan scheduler: level encodings, FSM states,
// default thresholds and the sample classifier.
package emission_scan_scheduler_pkg;

  localparam logic [1:0] LvlNormal = 2'b00;
  localparam logic [1:0] LvlWarn   = 2'b01;
  localparam logic [1:0] LvlCrit   = 2'b10;

  localparam int unsigned DefWarnTh   = 50;
  localparam int unsigned DefCritTh   = 100;
  localparam int unsigned DefDebounce = 3;
  localparam int unsigned DefTimeout  = 15;

  typedef enum logic [2:0] {
    StIdle,
    StSelect,
    StReq,
    StUpdate,
    StNext
  } state_e;

  function automatic logic [1:0] classify(input logic [7:0] data,
                                          input int unsigned warn_th,
                                          input int unsigned crit_th);
    if (32'(data) >= crit_th) return LvlCrit;
    if (32'(data) >= warn_th) return LvlWarn;
    return LvlNormal;
  endfunction

endpackage

// File: rtl/emission_level_filter.sv
// Classifies one sample and applies the per-channel debounce rule; purely combinational,
// shared across channels by the scheduler.
module emission_level_filter
  import emission_scan_scheduler_pkg::*;
#(
  parameter int unsigned WarnTh   = DefWarnTh,
  parameter int unsigned CritTh   = DefCritTh,
  parameter int unsigned Debounce = DefDebounce,
  parameter int unsigned CntW     = 2
) (
  input  logic [7:0]      sample_i,
  input  logic [1:0]      level_i,
  input  logic [1:0]      cand_i,
  input  logic [CntW-1:0] cnt_i,
  output logic [1:0]      level_o,
  output logic [1:0]      cand_o,
  output logic [CntW-1:0] cnt_o
);

  logic [1:0]  cls;
  int unsigned cnt_inc;

  always_comb begin
    cls     = classify(sample_i, WarnTh, CritTh);
    level_o = level_i;
    cand_o  = cand_i;
    cnt_o   = cnt_i;
    cnt_inc = 1;
    if (cls == level_i) begin
      cnt_o = '0;
    end else if (cls == LvlCrit) begin
      // Escalation to critical bypasses the debounce.
      level_o = LvlCrit;
      cnt_o   = '0;
    end else begin
      cand_o = cls;
      if (cls == cand_i) begin
        cnt_inc = (32'(cnt_i) >= Debounce) ? Debounce : 32'(cnt_i) + 1;
      end
      if (cnt_inc >= Debounce) begin
        level_o = cls;
        cnt_o   = '0;
      end else begin
        cnt_o = CntW'(cnt_inc);
      end
    end
  end

endmodule

// File: rtl/emission_scan_scheduler.sv
// Round-robin CO2 sensor scheduler: requests samples channel by channel, debounces the
// classified levels and raises aggregate warning/critical flags.
module emission_scan_scheduler
  import emission_scan_scheduler_pkg::*;
#(
  parameter int unsigned NumCh    = 4,
  parameter int unsigned ChW      = 2,
  parameter int unsigned WarnTh   = DefWarnTh,
  parameter int unsigned CritTh   = DefCritTh,
  parameter int unsigned Debounce = DefDebounce,
  parameter int unsigned Timeout  = DefTimeout
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               enable_i,
  input  logic [NumCh-1:0]   ch_mask_i,
  output logic               sample_req_o,
  output logic [ChW-1:0]     sample_ch_o,
  input  logic               sample_ack_i,
  input  logic [7:0]         sample_data_i,
  output logic [2*NumCh-1:0] ch_level_o,
  output logic               warning_o,
  output logic               critical_o,
  output logic               scan_done_o,
  output logic [NumCh-1:0]   sensor_fault_o
);

  localparam int unsigned CntW = $clog2(Debounce + 1);
  localparam int unsigned TmrW = $clog2(Timeout + 1);
  localparam logic [TmrW-1:0] TmrLast = TmrW'(Timeout - 1);

  state_e            state_q;
  logic [ChW-1:0]    ptr_q, cur_q, idx, sel_ch;
  logic [7:0]        data_q;
  logic [TmrW-1:0]   tmr_q;
  logic              sample_req_q, scan_done_q, found, more_above, warn_any, crit_any;
  logic [NumCh-1:0]  fault_q;
  logic [1:0]        level_q [NumCh];
  logic [1:0]        cand_q  [NumCh];
  logic [CntW-1:0]   cnt_q   [NumCh];
  logic [1:0]        f_level, f_cand;
  logic [CntW-1:0]   f_cnt;

  // First enabled channel at or after ptr, wrapping; descending loop keeps the nearest.
  always_comb begin
    found  = 1'b0;
    sel_ch = '0;
    idx    = '0;
    for (int i = NumCh - 1; i >= 0; i--) begin
      idx = ChW'((32'(ptr_q) + 32'(i)) % NumCh);
      if (ch_mask_i[idx]) begin
        found  = 1'b1;
        sel_ch = idx;
      end
    end
  end

  always_comb begin
    more_above = 1'b0;
    for (int unsigned i = 0; i < NumCh; i++) begin
      if (i > 32'(cur_q) && ch_mask_i[i]) more_above = 1'b1;
    end
  end

  emission_level_filter #(
    .WarnTh   (WarnTh),
    .CritTh   (CritTh),
    .Debounce (Debounce),
    .CntW     (CntW)
  ) u_filter (
    .sample_i (data_q),
    .level_i  (level_q[cur_q]),
    .cand_i   (cand_q[cur_q]),
    .cnt_i    (cnt_q[cur_q]),
    .level_o  (f_level),
    .cand_o   (f_cand),
    .cnt_o    (f_cnt)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      ptr_q        <= '0;
      cur_q        <= '0;
      data_q       <= '0;
      tmr_q        <= '0;
      sample_req_q <= 1'b0;
      scan_done_q  <= 1'b0;
      fault_q      <= '0;
      for (int i = 0; i < NumCh; i++) begin
        level_q[i] <= LvlNormal;
        cand_q[i]  <= LvlNormal;
        cnt_q[i]   <= '0;
      end
    end else begin
      scan_done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (enable_i && |ch_mask_i) state_q <= StSelect;
        end
        StSelect: begin
          if (found) begin
            cur_q        <= sel_ch;
            tmr_q        <= '0;
            sample_req_q <= 1'b1;
            state_q      <= StReq;
          end else begin
            state_q <= StIdle;
          end
        end
        StReq: begin
          if (sample_ack_i) begin
            data_q       <= sample_data_i;
            sample_req_q <= 1'b0;
            state_q      <= StUpdate;
          end else if (tmr_q == TmrLast) begin
            fault_q[cur_q] <= 1'b1;
            cnt_q[cur_q]   <= '0;
            sample_req_q   <= 1'b0;
            scan_done_q    <= ~more_above;
            state_q        <= StNext;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        StUpdate: begin
          level_q[cur_q] <= f_level;
          cand_q[cur_q]  <= f_cand;
          cnt_q[cur_q]   <= f_cnt;
          scan_done_q    <= ~more_above;
          state_q        <= StNext;
        end
        StNext: begin
          ptr_q   <= ChW'((32'(cur_q) + 1) % NumCh);
          state_q <= enable_i ? StSelect : StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    warn_any   = 1'b0;
    crit_any   = 1'b0;
    ch_level_o = '0;
    for (int unsigned i = 0; i < NumCh; i++) begin
      ch_level_o[2*i +: 2] = level_q[i];
      if (ch_mask_i[i] && level_q[i] == LvlCrit) crit_any = 1'b1;
      if (ch_mask_i[i] && level_q[i] == LvlWarn) warn_any = 1'b1;
    end
  end

  assign critical_o     = crit_any;
  assign warning_o      = warn_any & ~crit_any;
  assign sample_req_o   = sample_req_q;
  assign sample_ch_o    = cur_q;
  assign scan_done_o    = scan_done_q;
  assign sensor_fault_o = fault_q;

endmodule

// File: tb/tb_emission_scan_scheduler.sv
// Bench for emission_scan_scheduler: acts as the sensor, tracks the expected channel order,
// levels and faults with a transaction-level model, and compares after every sample.
module tb_emission_scan_scheduler;

  localparam int NumCh    = 4;
  localparam int WarnTh   = 50;
  localparam int CritTh   = 100;
  localparam int Debounce = 3;
  localparam int Timeout  = 15;

  logic       clk_i = 1'b0;
  logic       rst_ni, enable_i, sample_ack_i;
  logic [3:0] ch_mask_i;
  logic [7:0] sample_data_i;
  logic       sample_req_o, warning_o, critical_o, scan_done_o;
  logic [1:0] sample_ch_o;
  logic [7:0] ch_level_o;
  logic [3:0] sensor_fault_o;

  always #5 clk_i = ~clk_i;

  emission_scan_scheduler #(
    .NumCh    (NumCh),
    .ChW      (2),
    .WarnTh   (WarnTh),
    .CritTh   (CritTh),
    .Debounce (Debounce),
    .Timeout  (Timeout)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .enable_i       (enable_i),
    .ch_mask_i      (ch_mask_i),
    .sample_req_o   (sample_req_o),
    .sample_ch_o    (sample_ch_o),
    .sample_ack_i   (sample_ack_i),
    .sample_data_i  (sample_data_i),
    .ch_level_o     (ch_level_o),
    .warning_o      (warning_o),
    .critical_o     (critical_o),
    .scan_done_o    (scan_done_o),
    .sensor_fault_o (sensor_fault_o)
  );

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Reference state: level/candidate/count per channel, faults, scan pointer, mask.
  int         m_lvl[4], m_cand[4], m_cnt[4];
  logic [3:0] m_fault, m_mask;
  int         m_ptr;
  int         ch_data[4];
  int         ch_delay[4];  // -1 means the sensor never answers

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic int classify(input int d);
    if (d < WarnTh) return 0;
    if (d < CritTh) return 1;
    return 2;
  endfunction

  function automatic void model_sample(input int ch, input int d);
    int c;
    c = classify(d);
    if (c == m_lvl[ch]) begin
      m_cnt[ch] = 0;
    end else if (c == 2) begin
      m_lvl[ch] = 2;
      m_cnt[ch] = 0;
    end else begin
      if (c == m_cand[ch]) m_cnt[ch] = (m_cnt[ch] + 1 > Debounce) ? Debounce : m_cnt[ch] + 1;
      else begin
        m_cand[ch] = c;
        m_cnt[ch]  = 1;
      end
      if (m_cnt[ch] >= Debounce) begin
        m_lvl[ch] = c;
        m_cnt[ch] = 0;
      end
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      m_lvl[i]  = 0;
      m_cand[i] = 0;
      m_cnt[i]  = 0;
    end
    m_fault = '0;
    m_ptr   = 0;
  endfunction

  function automatic int next_ch();
    for (int i = 0; i < 4; i++) begin
      if (m_mask[(m_ptr + i) % 4]) return (m_ptr + i) % 4;
    end
    return -1;
  endfunction

  function automatic bit more_above(input int c);
    for (int i = c + 1; i < 4; i++) if (m_mask[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [7:0] exp_levels();
    logic [7:0] v;
    for (int i = 0; i < 4; i++) v[2*i +: 2] = 2'(m_lvl[i]);
    return v;
  endfunction

  function automatic bit exp_crit();
    for (int i = 0; i < 4; i++) if (m_mask[i] && m_lvl[i] == 2) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit exp_warn();
    if (exp_crit()) return 1'b0;
    for (int i = 0; i < 4; i++) if (m_mask[i] && m_lvl[i] == 1) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check_state();
    check_val("levels", ch_level_o, exp_levels());
    check_val("warning", warning_o, exp_warn());
    check_val("critical", critical_o, exp_crit());
    check_val("fault", sensor_fault_o, m_fault);
  endtask

  // Serve one request end to end; returns at the NEXT-state negedge (one later on timeout).
  task automatic serve(input bit drop_en, input bit chg_mask, input logic [3:0] new_mask);
    int  exp_ch, n, dly;
    bit  seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (sample_req_o) begin
        seen = 1'b1;
        break;
      end
    end
    check_val("req_seen", seen, 1);
    if (!seen) return;
    exp_ch = next_ch();
    check_val("req_ch", sample_ch_o, exp_ch);
    if (exp_ch < 0) return;
    if (drop_en) enable_i = 1'b0;
    if (chg_mask) begin
      m_mask    = new_mask;
      ch_mask_i = new_mask;
    end
    dly = ch_delay[exp_ch];
    if (dly < 0) begin
      n = 1;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk_i);
        if (!sample_req_o) break;
        n++;
      end
      check_val("req_len", n, Timeout);
      m_fault[exp_ch] = 1'b1;
      m_cnt[exp_ch]   = 0;
      sample_ack_i  = 1'b1;  // late ack, must be ignored
      sample_data_i = 8'd200;
    end else begin
      for (int i = 0; i < dly; i++) begin
        @(negedge clk_i);
        check_val("req_hold", sample_req_o, 1);
      end
      sample_ack_i  = 1'b1;
      sample_data_i = 8'(ch_data[exp_ch]);
      @(negedge clk_i);
      sample_ack_i = 1'b0;
      check_val("req_drop", sample_req_o, 0);
      @(negedge clk_i);
      model_sample(exp_ch, ch_data[exp_ch]);
    end
    check_val("scan_done", scan_done_o, !more_above(exp_ch));
    m_ptr = (exp_ch + 1) % 4;
    check_state();
    if (dly < 0) begin
      @(negedge clk_i);
      sample_ack_i = 1'b0;
    end
  endtask

  task automatic idle_check(input string tag);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      check_val(tag, sample_req_o, 0);
    end
  endtask

  int  t1, t2;
  bit  seen6;

  initial begin
    rst_ni = 1'b0; enable_i = 1'b0; ch_mask_i = 4'b0000; m_mask = 4'b0000;
    sample_ack_i = 1'b0; sample_data_i = 8'd0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      ch_data[i]  = 20;
      ch_delay[i] = 0;
    end
    repeat (2) @(negedge clk_i);
    check_val("rst_req", sample_req_o, 0);
    check_val("rst_ch", sample_ch_o, 0);
    check_val("rst_done", scan_done_o, 0);
    check_state();

    // 1: all channels quiet, back-to-back sweeps of 16 cycles
    ch_mask_i = 4'b1111; m_mask = 4'b1111; enable_i = 1'b1;
    ch_data[0] = 49;
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (4) serve(0, 0, 4'b0);
    t1 = cyc;
    repeat (4) serve(0, 0, 4'b0);
    t2 = cyc;
    check_val("sweep_cycles", t2 - t1, 16);
    ch_data[0] = 20;

    // 2: ch1 warns after three samples and needs three normals to recover
    ch_data[1] = 70;
    repeat (12) serve(0, 0, 4'b0);
    check_val("t2_lvl1", ch_level_o[3:2], 1);
    check_val("t2_warn", warning_o, 1);
    ch_data[1] = 20;
    repeat (4) serve(0, 0, 4'b0);
    check_val("t2_hold", ch_level_o[3:2], 1);
    repeat (8) serve(0, 0, 4'b0);
    check_val("t2_normal", ch_level_o[3:2], 0);

    // 3: single critical sample escalates immediately and masks the warning
    ch_data[1] = 70;
    repeat (12) serve(0, 0, 4'b0);
    ch_data[2] = 100;
    repeat (3) serve(0, 0, 4'b0);
    check_val("t3_lvl2", ch_level_o[5:4], 2);
    check_val("t3_crit", critical_o, 1);
    check_val("t3_warn", warning_o, 0);
    ch_data[2] = 20;

    // 4: ch3 never answers, then ch0 acks on the last allowed cycle
    ch_delay[3] = -1;
    serve(0, 0, 4'b0);
    check_val("t4_fault", sensor_fault_o, 4'b1000);
    ch_delay[3] = 0;
    ch_delay[0] = Timeout - 1;
    serve(0, 0, 4'b0);
    ch_delay[0] = 0;

    // 5: partial mask, enable drop mid-request, mask cleared mid-request
    ch_mask_i = 4'b0101; m_mask = 4'b0101;
    repeat (3) serve(0, 0, 4'b0);
    serve(1, 0, 4'b0);
    idle_check("t5_en_idle");
    enable_i = 1'b1;
    serve(0, 0, 4'b0);
    serve(0, 1, 4'b0000);
    idle_check("t5_mask_idle");
    check_val("t5_warn_masked", warning_o, 0);
    check_val("t5_crit_masked", critical_o, 0);

    // Random traffic
    ch_mask_i = 4'b1111; m_mask = 4'b1111;
    for (int it = 0; it < 80; it++) begin
      for (int c = 0; c < 4; c++) begin
        if ($urandom_range(0, 1) == 0) begin
          case ($urandom_range(0, 2))
            0:       ch_data[c] = int'($urandom_range(0, 49));
            1:       ch_data[c] = int'($urandom_range(50, 99));
            default: ch_data[c] = int'($urandom_range(100, 255));
          endcase
        end
        ch_delay[c] = ($urandom_range(0, 19) == 0) ? -1 : int'($urandom_range(0, 3));
      end
      serve(0, 0, 4'b0);
      if (it % 8 == 7) begin
        m_mask    = 4'($urandom_range(1, 15));
        ch_mask_i = m_mask;
      end
    end

    // 6: async reset while a request is outstanding, restart at ch0
    ch_mask_i = 4'b1111; m_mask = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      ch_delay[c] = 0;
      ch_data[c]  = 150;
    end
    repeat (4) serve(0, 0, 4'b0);
    seen6 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (sample_req_o) begin
        seen6 = 1'b1;
        break;
      end
    end
    check_val("t6_req_seen", seen6, 1);
    #2 rst_ni = 1'b0;
    #1;
    check_val("t6_req", sample_req_o, 0);
    check_val("t6_ch", sample_ch_o, 0);
    check_val("t6_levels", ch_level_o, 0);
    check_val("t6_warn", warning_o, 0);
    check_val("t6_crit", critical_o, 0);
    check_val("t6_done", scan_done_o, 0);
    check_val("t6_fault", sensor_fault_o, 0);
    model_reset();
    ch_data[0] = 20;
    @(negedge clk_i);
    rst_ni = 1'b1;
    serve(0, 0, 4'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
